// File: rtl/crc_stream_engine_if.sv
// Stream and result bundle for crc_stream_engine.
// Ports:
//   s_valid/s_ready/s_data/s_last  - input beat handshake and framing
//   s_mode/s_exp_crc/s_abort       - per-frame control
//   crc_out/crc_valid/crc_ready    - result handshake
//   crc_match/frame_len/busy       - result details and status
// Modports: master drives beats and accepts results, slave is the engine.
interface crc_stream_engine_if #(
    parameter int DATA_W = 16,
    parameter int CRC_W  = 16,
    parameter int LEN_W  = 16
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_mode;
    logic [CRC_W-1:0]  s_exp_crc;
    logic              s_abort;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_valid;
    logic              crc_ready;
    logic              crc_match;
    logic [LEN_W-1:0]  frame_len;
    logic              busy;

    modport master (
        output s_valid, s_data, s_last, s_mode,
        output s_exp_crc, s_abort, crc_ready,
        input  s_ready, crc_out, crc_valid,
        input  crc_match, frame_len, busy
    );

    modport slave (
        input  s_valid, s_data, s_last, s_mode,
        input  s_exp_crc, s_abort, crc_ready,
        output s_ready, crc_out, crc_valid,
        output crc_match, frame_len, busy
    );

endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker folding DATA_W bits per accepted beat.
// Ports:
//   clk_in - system clock
//   rst    - asynchronous reset, active high
//   bus    - slave side of crc_stream_engine_if (beats in, result out)
// One registered result per frame; held in HOLD until crc_ready.
module crc_stream_engine #(
    parameter int               DATA_W     = 16,
    parameter int               CRC_W      = 16,
    parameter logic [CRC_W-1:0] POLY       = 16'h1021,
    parameter logic [CRC_W-1:0] INIT       = '0,
    parameter logic [CRC_W-1:0] XOR_OUT    = '0,
    parameter bit               REFLECT_IN = 1'b0,
    parameter int               LEN_W      = 16
) (
    input logic                clk_in,
    input logic                rst,
    crc_stream_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CRC_W-1:0]  crc_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              mode_q;
    logic [CRC_W-1:0]  crc_out_q;
    logic              match_q;
    logic [LEN_W-1:0]  len_q;

    logic [DATA_W-1:0] din;
    logic [CRC_W-1:0]  fold;
    logic              fb;
    logic [CRC_W-1:0]  res;
    logic [LEN_W-1:0]  cnt_next;
    logic              mode_now;
    logic              ready;
    logic              take;
    logic              drop;

    assign ready = (state_q != HOLD);

    // Abort wins over a beat in the same cycle; ignored once the
    // result is complete.
    assign take = bus.s_valid & ready & ~bus.s_abort;
    assign drop = bus.s_abort & ready;

    // Whole-word fold, MSB of the (optionally reversed) word first.
    // A frame's first beat starts from INIT, not the stored register.
    always_comb begin
        din  = '0;
        fb   = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (REFLECT_IN)
                din[i] = bus.s_data[DATA_W-1-i];
            else
                din[i] = bus.s_data[i];
        end
        fold = (state_q == IDLE) ? INIT : crc_q;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb   = fold[CRC_W-1] ^ din[i];
            fold = (fold << 1) ^ (fb ? POLY : '0);
        end
    end

    assign res = fold ^ XOR_OUT;

    // Mode is taken live on the first beat, so a one-beat frame
    // still honours it.
    assign mode_now = (state_q == IDLE) ? bus.s_mode : mode_q;

    always_comb begin
        cnt_next = cnt_q;
        if (state_q == IDLE)
            cnt_next = LEN_W'(1);
        else if (cnt_q != {LEN_W{1'b1}})
            cnt_next = cnt_q + LEN_W'(1);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (take)
                    state_d = bus.s_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (drop)
                    state_d = IDLE;
                else if (take && bus.s_last)
                    state_d = HOLD;
            end
            HOLD: begin
                if (bus.crc_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            crc_q     <= INIT;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            crc_out_q <= '0;
            match_q   <= 1'b0;
            len_q     <= '0;
        end else if (take) begin
            if (state_q == IDLE)
                mode_q <= bus.s_mode;
            if (bus.s_last) begin
                // Re-arm for the next frame while publishing the result.
                crc_q     <= INIT;
                cnt_q     <= '0;
                crc_out_q <= res;
                len_q     <= cnt_next;
                match_q   <= mode_now & (res == bus.s_exp_crc);
            end else begin
                crc_q <= fold;
                cnt_q <= cnt_next;
            end
        end else if (drop) begin
            crc_q <= INIT;
            cnt_q <= '0;
        end
    end

    assign bus.s_ready   = ready;
    assign bus.crc_valid = (state_q == HOLD);
    assign bus.crc_out   = crc_out_q;
    assign bus.crc_match = match_q;
    assign bus.frame_len = len_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
Parametrised streaming CRC generator/checker, the successor to the fixed 16-bit CRC-16 (x^16+x^12+x^5+1) engine. Accepts framed data words over a valid/ready handshake and folds DATA_W bits per accepted beat. Polynomial, init and output XOR are set at elaboration. Each frame produces one registered result with optional compare against an expected CRC. Sits between the packet framer and the link transmitter/receiver.

Parameters:
DATA_W, 16, input word width (1..64)
CRC_W, 16, CRC width (8..32)
POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term
INIT, 0, CRC register value at start of each frame
XOR_OUT, 0, XORed into the final CRC before output
REFLECT_IN, 0, 1 = bit-reverse each input word before folding
LEN_W, 16, frame beat counter width

Ports:
clk_in  in  1  system clock
rst  in  1  asynchronous reset, active high
s_valid  in  1  input beat valid
s_ready  out  1  engine can accept a beat
s_data  in  DATA_W  input word
s_last  in  1  beat is final word of frame
s_mode  in  1  0 = generate, 1 = check; sampled on first beat of frame
s_exp_crc  in  CRC_W  expected CRC; sampled on last beat in check mode
s_abort  in  1  discard current frame
crc_out  out  CRC_W  final CRC (after XOR_OUT)
crc_valid  out  1  result valid
crc_ready  in  1  downstream accepts result
crc_match  out  1  check mode: crc_out == sampled s_exp_crc; 0 in generate mode
frame_len  out  LEN_W  beats in the completed frame, saturating
busy  out  1  frame in progress or result pending

Behaviour:
- Reset (rst=1, async): state IDLE, crc_reg=INIT, crc_out=0, crc_valid=0, crc_match=0, frame_len=0, beat count=0, mode reg=0, busy=0. Reset mid-frame or while a result is pending drops it silently.
- Beat accepted when s_valid & s_ready. s_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- Fold: d = REFLECT_IN ? bitrev(s_data) : s_data. Process bits from d[DATA_W-1] down to d[0]: fb = c[CRC_W-1] ^ bit; c = (c << 1) ^ (fb ? POLY : 0). Unrolled in one cycle; one beat per clock sustained.
- States:
  - IDLE: on accept, c starts from INIT, mode captured, count=1. If s_last is set, go to HOLD; otherwise go to ACCUM.
  - ACCUM: on accept, c folds onto crc_reg and count increments, saturating at 2^LEN_W-1. If s_last is set, go to HOLD.
  - HOLD: crc_valid=1. Outputs are held stable until crc_valid & crc_ready, then go to IDLE and crc_valid=0.
- Result registered on the last-beat accept edge. crc_valid rises on the next cycle, giving 1-cycle latency. crc_out = c_final ^ XOR_OUT. crc_match = mode & (crc_out == s_exp_crc). frame_len = count including the last beat.
- A beat presented in the same cycle as the HOLD handshake is not accepted (s_ready=0). It is accepted on the following cycle, in IDLE.
- s_abort has priority over a simultaneous beat. In IDLE/ACCUM it discards the beat, returns to IDLE and restores INIT. In HOLD it is ignored (result already complete).
- Between frames, crc_reg is restored to INIT, not zero.
- busy = (state != IDLE).
- s_mode and s_exp_crc are ignored when not sampled.

Test Plan:
1. DATA_W=8, POLY=16'h1021, INIT=0, XOR_OUT=0; bytes "123456789" (0x31..0x39), s_last on 0x39, s_mode=0, crc_ready=1 -> crc_out=16'h31C3, frame_len=9, crc_valid high exactly one cycle, 1 cycle after last accept.
2. Same with INIT=16'hFFFF -> crc_out=16'h29B1. Then frame 2 with s_mode=1 and s_exp_crc=16'h29B1 -> crc_match=1. Frame 3 with s_exp_crc=16'h29B0 -> crc_match=0.
3. Defaults; single beat s_data=16'h0001 with s_last=1 -> crc_out=16'h1021, frame_len=1. Then s_data=16'h0000 with s_last=1 -> crc_out=16'h0000, showing INIT is restored between frames.
4. Backpressure: hold crc_ready=0 for 5 cycles after a result, with s_valid=1 continuously -> s_ready=0, crc_out and crc_valid stable throughout. The next frame's first beat is accepted the cycle after the crc_ready handshake.
5. Abort: feed 3 beats of frame A, assert s_abort with a valid beat in the same cycle, then send frame "123456789" (DATA_W=8) -> result is 16'h31C3 and frame_len=9, with no contamination from frame A.
6. Assert rst asynchronously mid-frame and again during HOLD -> all outputs go to their reset values immediately. A following clean frame gives the correct CRC. LEN_W=2 with a 5-beat frame -> frame_len=3 (saturated).
